// File: rtl/tone_period_decoder_if.sv
// ---------------------------------------------------------------------------
// tone_period_decoder_if
//   Bundles the tone input, the synchronous clear and all measurement results
//   of tone_period_decoder so the decoder and its user connect through one port.
//
// Handshake: there is no backpressure. `valid` is a one-cycle strobe that is
// high during the cycle after freq_div_out was (re)written while locked. The
// consumer must take freq_div_out in that cycle. `timeout_err` is a one-cycle
// strobe with the same timing. `locked` and `tone_active` are levels.
//
// Signals
//   tone_in      master -> slave  asynchronous square-wave input
//   clr          master -> slave  synchronous clear
//   freq_div_out slave -> master  last locked half-period (clk cycles), 0 = none
//   valid        slave -> master  strobe: freq_div_out updated while locked
//   locked       slave -> master  level: tone stable within tolerance
//   tone_active  slave -> master  level: edge seen, no timeout since
//   timeout_err  slave -> master  strobe: silence timeout
//   state_dbg    slave -> master  FSM state for observation (0 IDLE, 1 ARMED, 2 TRACK)
// ---------------------------------------------------------------------------
interface tone_period_decoder_if #(
   parameter int CNT_W = 20
);
   logic             tone_in;
   logic             clr;
   logic [CNT_W-1:0] freq_div_out;
   logic             valid;
   logic             locked;
   logic             tone_active;
   logic             timeout_err;
   logic [1:0]       state_dbg;

   modport master (
      output tone_in, clr,
      input  freq_div_out, valid, locked, tone_active, timeout_err, state_dbg
   );

   modport slave (
      input  tone_in, clr,
      output freq_div_out, valid, locked, tone_active, timeout_err, state_dbg
   );
endinterface

// File: rtl/tone_period_decoder.sv
// ---------------------------------------------------------------------------
// tone_period_decoder
//   Measures the half-period of an incoming square wave (clk cycles between
//   successive transitions, both polarities) and reports it in the same
//   freq_div encoding the piezo generator accepts. A result is published only
//   after STABLE_N consecutive samples each within TOL of the one before.
//   A silence of MAX_HALF cycles drops back to IDLE and clears the result.
//
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    tone_period_decoder_if.slave (tone_in, clr in; results out)
// ---------------------------------------------------------------------------
module tone_period_decoder #(
   parameter int CNT_W    = 20,
   parameter int MAX_HALF = 1_000_000,
   parameter int STABLE_N = 2,
   parameter int TOL      = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   tone_period_decoder_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      TRACK = 2'd2
   } state_t;

   localparam int               MC_W     = $clog2(STABLE_N + 1);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HALF);
   localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);
   localparam logic [MC_W-1:0]  STABLE_C = MC_W'(STABLE_N);

   logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] prev_q, prev_d;
   logic [MC_W-1:0]  mc_q, mc_d;
   logic [CNT_W-1:0] fdo_q, fdo_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             active_q, active_d;
   logic             to_err_q, to_err_d;
   logic             to_done_q, to_done_d;   // timeout already reported; blocks repeats

   logic             edge_det;
   logic [CNT_W-1:0] diff;
   logic             is_match;
   logic [MC_W-1:0]  mc_inc;

   always_comb begin
      s1_d      = bus.tone_in;
      s2_d      = s1_q;
      s3_d      = s2_q;
      edge_det  = s2_q ^ s3_q;

      // The counter is restarted at 1 on each edge, so at the next edge it
      // holds exactly the number of cycles between the two edges.
      diff      = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
      is_match  = (diff <= TOL_C);
      mc_inc    = (mc_q == STABLE_C) ? mc_q : (mc_q + MC_W'(1));

      state_d   = state_q;
      cnt_d     = (cnt_q == MAX_C) ? cnt_q : (cnt_q + CNT_W'(1));
      prev_d    = prev_q;
      mc_d      = mc_q;
      fdo_d     = fdo_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      active_d  = active_q;
      to_err_d  = 1'b0;
      to_done_d = to_done_q;

      if (bus.clr) begin
         // Synchroniser flops keep running so no spurious edge follows clr.
         state_d   = IDLE;
         cnt_d     = '0;
         prev_d    = '0;
         mc_d      = '0;
         fdo_d     = '0;
         locked_d  = 1'b0;
         active_d  = 1'b0;
         to_done_d = 1'b0;
      end else if (edge_det) begin
         cnt_d     = CNT_W'(1);
         to_done_d = 1'b0;
         case (state_q)
            IDLE: begin
               state_d  = ARMED;
               active_d = 1'b1;
            end
            ARMED: begin
               state_d = TRACK;
               prev_d  = cnt_q;
               mc_d    = '0;
            end
            TRACK: begin
               prev_d = cnt_q;
               if (is_match) begin
                  mc_d = mc_inc;
                  if (mc_inc == STABLE_C) begin
                     locked_d = 1'b1;
                     fdo_d    = cnt_q;
                     valid_d  = 1'b1;
                  end
               end else begin
                  mc_d     = '0;
                  locked_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if ((cnt_q == MAX_C) && !to_done_q) begin
         state_d   = IDLE;
         mc_d      = '0;
         fdo_d     = '0;
         locked_d  = 1'b0;
         active_d  = 1'b0;
         to_err_d  = 1'b1;
         to_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         prev_q    <= '0;
         mc_q      <= '0;
         fdo_q     <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         active_q  <= 1'b0;
         to_err_q  <= 1'b0;
         to_done_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prev_q    <= prev_d;
         mc_q      <= mc_d;
         fdo_q     <= fdo_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         active_q  <= active_d;
         to_err_q  <= to_err_d;
         to_done_q <= to_done_d;
      end
   end

   assign bus.freq_div_out = fdo_q;
   assign bus.valid        = valid_q;
   assign bus.locked       = locked_q;
   assign bus.tone_active  = active_q;
   assign bus.timeout_err  = to_err_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_tone_period_decoder.sv
module tb_tone_period_decoder;

   localparam int CNT_W    = 20;
   localparam int MAX_HALF = 1000;

   logic clk;
   logic rst_n;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   valid_cnt = 0;
   int   to_cnt    = 0;

   tone_period_decoder_if #(.CNT_W(CNT_W)) bus ();

   tone_period_decoder #(
      .CNT_W(CNT_W), .MAX_HALF(MAX_HALF), .STABLE_N(2), .TOL(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // strobe counters, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.valid === 1'b1)       valid_cnt++;
      if (bus.timeout_err === 1'b1) to_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Toggle tone_in `gap` cycles after the previous toggle, then wait until
   // the registered outputs reflect this edge (3 clocks after the toggle).
   task automatic edge_at(input int gap);
      repeat (gap - 3) tick();
      bus.tone_in = ~bus.tone_in;
      repeat (3) tick();
   endtask

   task automatic chk_lock(input string name, input logic exp_locked,
                           input logic [CNT_W-1:0] exp_fdo, input logic exp_valid);
      chk_cnt++;
      if (bus.locked !== exp_locked || bus.freq_div_out !== exp_fdo || bus.valid !== exp_valid)
         $display("FAIL %s: locked=%0b fdo=%0d valid=%0b, expected locked=%0b fdo=%0d valid=%0b",
                  name, bus.locked, bus.freq_div_out, bus.valid, exp_locked, exp_fdo, exp_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.tone_in = 1'b0;
      bus.clr = 1'b0;
      repeat (3) tick();
      chk_cnt++;
      if ({bus.freq_div_out, bus.valid, bus.locked, bus.tone_active, bus.timeout_err} !== '0)
         $display("FAIL reset_outputs: fdo=%0d v=%0b l=%0b a=%0b t=%0b, expected all 0",
                  bus.freq_div_out, bus.valid, bus.locked, bus.tone_active, bus.timeout_err);
      else pass_cnt++;
      chk_cnt++;
      if (bus.state_dbg !== 2'd0) $display("FAIL reset_state: %0d expected 0", bus.state_dbg);
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_lock_100();
      int v0;
      v0 = valid_cnt;
      edge_at(3);
      chk_cnt++;
      if (bus.tone_active !== 1'b1 || bus.state_dbg !== 2'd1)
         $display("FAIL arm: active=%0b state=%0d expected 1/1", bus.tone_active, bus.state_dbg);
      else pass_cnt++;
      edge_at(100);
      chk_lock("lock_e2", 1'b0, 0, 1'b0);
      edge_at(100);
      chk_lock("lock_e3", 1'b0, 0, 1'b0);
      edge_at(100);
      chk_lock("lock_e4", 1'b1, 100, 1'b1);
      edge_at(100);
      edge_at(100);
      tick();
      chk_cnt++;
      if (valid_cnt - v0 !== 3) $display("FAIL valid_count: %0d expected 3", valid_cnt - v0);
      else pass_cnt++;
   endtask

   task automatic test_freq_change();
      edge_at(249);   // one cycle already spent after the last edge
      chk_lock("chg_drop", 1'b0, 100, 1'b0);
      edge_at(250);
      chk_lock("chg_e2", 1'b0, 100, 1'b0);
      edge_at(250);
      chk_lock("chg_relock", 1'b1, 250, 1'b1);
   endtask

   task automatic test_jitter();
      edge_at(100);
      chk_lock("jit_drop", 1'b0, 250, 1'b0);
      edge_at(100);
      edge_at(100);
      chk_lock("jit_lock", 1'b1, 100, 1'b1);
      edge_at(99);
      chk_lock("jit_99", 1'b1, 99, 1'b1);
      edge_at(100);
      chk_lock("jit_100", 1'b1, 100, 1'b1);
      edge_at(101);
      chk_lock("jit_101", 1'b1, 101, 1'b1);
      edge_at(100);
      chk_lock("jit_100b", 1'b1, 100, 1'b1);
      edge_at(102);
      chk_lock("jit_102", 1'b0, 100, 1'b0);
   endtask

   task automatic test_timeout();
      int t0;
      edge_at(100);
      edge_at(100);
      edge_at(100);
      chk_lock("to_lock", 1'b1, 100, 1'b1);
      t0 = to_cnt;
      repeat (999) tick();
      chk_cnt++;
      if (bus.timeout_err !== 1'b0 || bus.locked !== 1'b1)
         $display("FAIL to_early: terr=%0b locked=%0b expected 0/1", bus.timeout_err, bus.locked);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (bus.timeout_err !== 1'b1 || bus.locked !== 1'b0 || bus.tone_active !== 1'b0 ||
          bus.freq_div_out !== '0 || bus.state_dbg !== 2'd0)
         $display("FAIL to_fire: terr=%0b l=%0b a=%0b fdo=%0d st=%0d expected 1/0/0/0/0",
                  bus.timeout_err, bus.locked, bus.tone_active, bus.freq_div_out, bus.state_dbg);
      else pass_cnt++;
      repeat (1100) tick();
      chk_cnt++;
      if (to_cnt - t0 !== 1) $display("FAIL to_once: %0d pulses expected 1", to_cnt - t0);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_track();
      edge_at(3);
      edge_at(100);
      edge_at(100);
      edge_at(100);
      chk_lock("rst_prelock", 1'b1, 100, 1'b1);
      rst_n = 1'b0;
      bus.tone_in = 1'b0;
      #1;
      chk_cnt++;
      if ({bus.freq_div_out, bus.locked, bus.tone_active, bus.valid} !== '0)
         $display("FAIL rst_async: fdo=%0d l=%0b a=%0b v=%0b expected all 0",
                  bus.freq_div_out, bus.locked, bus.tone_active, bus.valid);
      else pass_cnt++;
      #1;
      rst_n = 1'b1;
      tick();
      edge_at(3);
      chk_lock("rst_e1", 1'b0, 0, 1'b0);
      edge_at(100);
      edge_at(100);
      chk_lock("rst_e3", 1'b0, 0, 1'b0);
      edge_at(100);
      chk_lock("rst_e4", 1'b1, 100, 1'b1);
   endtask

   task automatic test_clr_with_edge();
      repeat (10) tick();
      bus.tone_in = ~bus.tone_in;
      tick();
      tick();
      bus.clr = 1'b1;
      tick();
      chk_cnt++;
      if ({bus.freq_div_out, bus.locked, bus.tone_active, bus.valid} !== '0 || bus.state_dbg !== 2'd0)
         $display("FAIL clr_edge: fdo=%0d l=%0b a=%0b v=%0b st=%0d expected all 0",
                  bus.freq_div_out, bus.locked, bus.tone_active, bus.valid, bus.state_dbg);
      else pass_cnt++;
      bus.clr = 1'b0;
      tick();
      chk_cnt++;
      if (bus.tone_active !== 1'b0 || bus.state_dbg !== 2'd0)
         $display("FAIL clr_edge_lost: active=%0b state=%0d expected 0/0", bus.tone_active, bus.state_dbg);
      else pass_cnt++;
      edge_at(3);
      edge_at(100);
      edge_at(100);
      chk_lock("clr_e3", 1'b0, 0, 1'b0);
      edge_at(100);
      chk_lock("clr_e4", 1'b1, 100, 1'b1);
   endtask

   task automatic test_fastest();
      int t0;
      t0 = to_cnt;
      for (int i = 0; i < 60; i++) begin
         bus.tone_in = ~bus.tone_in;
         tick();
      end
      chk_cnt++;
      if (bus.locked !== 1'b1 || bus.freq_div_out !== 20'd1)
         $display("FAIL fast: locked=%0b fdo=%0d expected 1/1", bus.locked, bus.freq_div_out);
      else pass_cnt++;
      chk_cnt++;
      if (to_cnt !== t0) $display("FAIL fast_no_to: %0d extra timeouts", to_cnt - t0);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_lock_100();
      test_freq_change();
      test_jitter();
      test_timeout();
      test_reset_mid_track();
      test_clr_with_edge();
      test_fastest();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
